cam_channel_scheduler: RTL and testbench

Round-robin scheduler that shares the single DDR2 frame-write master between the camera input channels. The software-written channel-count register (4-bit PIO output) sets how many channels take part. Each channel raises a request once it has a full burst buffered. The scheduler grants one channel at a time, holds the grant until the write master reports the burst complete, and guards each burst with a timeout. It sits between the per-channel line FIFOs and the Avalon-MM write master in the QSYS system.

---
 rtl/cam_sched_pkg.sv | 22 ++
 rtl/cam_rr_arbiter.sv | 38 +++
 rtl/cam_channel_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_cam_channel_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_sched_pkg.sv
// Shared types and constants for the camera channel scheduler.
// The optional per-channel burst statistics block is enabled by the
// CAM_SCHED_STATS_EN macro (see cam_channel_scheduler.sv).
package cam_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BURST = 2'd2
  } sched_state_e;

  // Width of the software channel-count register
  localparam int CNT_W = 4;

  // Width of each per-channel burst statistics counter
  localparam int STAT_W = 16;

  // Default burst timeout in cycles
  localparam int TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/cam_rr_arbiter.sv
// Rotating-priority search: starting at index 'start' and wrapping, the
// first set bit of eff_req wins. Purely combinational; the scheduler
// registers the result. Bits above the active channel count are already
// masked off in eff_req, so wrapping at NUM_CH gives the same winner as
// wrapping at the active count.
module cam_rr_arbiter #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = 3
) (
  input  logic [NUM_CH-1:0] eff_req,
  input  logic [CH_W-1:0]   start,
  output logic              found,
  output logic [CH_W-1:0]   win
);

  localparam logic [CH_W:0] NUM_CH_X = (CH_W+1)'(NUM_CH);

  logic [CH_W:0]   sum;
  logic [CH_W-1:0] idx;

  // Walk the channels in priority order and keep the first requester
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, start} + (CH_W+1)'(i);
      if (sum >= NUM_CH_X) sum = sum - NUM_CH_X;
      idx = sum[CH_W-1:0];
      if (!found && eff_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/cam_channel_scheduler.sv
// Round-robin scheduler sharing the DDR2 frame-write master between camera
// channels. One grant at a time, held until the write master reports the
// burst done or the burst times out.
// Handshake: grant_valid stays high from the registered grant until
// burst_ack is sampled; a grant is never withdrawn once presented.
// Optional feature macro: CAM_SCHED_STATS_EN adds stat_sel/stat_count and
// one wrapping 16-bit completed-burst counter per channel.
module cam_channel_scheduler
  import cam_sched_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  no_of_cam_channels,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_ch,
  output logic              grant_valid,
  input  logic              burst_ack,
  input  logic              burst_done,
  output logic [CNT_W-1:0]  active_ch,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
`ifdef CAM_SCHED_STATS_EN
  ,
  input  logic [CH_W-1:0]   stat_sel,
  output logic [STAT_W-1:0] stat_count
`endif
);

  localparam int TO_W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] NUM_CH_C = CNT_W'(NUM_CH);

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  active_ch_q, active_ch_d;
  logic [CH_W-1:0]   last_ch_q, last_ch_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
  logic              grant_valid_q, grant_valid_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              timeout_err_q, timeout_err_d;

  logic [CNT_W-1:0]  clamp_cnt;
  logic [CNT_W:0]    next_idx;
  logic [NUM_CH-1:0] eff_req;
  logic [CH_W-1:0]   arb_start;
  logic              arb_found;
  logic [CH_W-1:0]   arb_win;
  logic              to_expired;

  // Eligibility and search start use the count being latched this cycle,
  // so a register write takes effect on the very next arbitration.
  always_comb begin
    clamp_cnt = (no_of_cam_channels > NUM_CH_C) ? NUM_CH_C : no_of_cam_channels;
    for (int i = 0; i < NUM_CH; i++) begin
      eff_req[i] = req[i] && (CNT_W'(i) < clamp_cnt);
    end
    // Start after the last served channel; restart at 0 on wrap or shrink
    next_idx  = (CNT_W+1)'(last_ch_q) + (CNT_W+1)'(1);
    arb_start = (next_idx >= {1'b0, clamp_cnt}) ? '0 : CH_W'(next_idx);
    to_expired = (to_cnt_q == TO_LAST);
  end

  cam_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .eff_req (eff_req),
    .start   (arb_start),
    .found   (arb_found),
    .win     (arb_win)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      active_ch_q   <= '0;
      last_ch_q     <= CH_W'(NUM_CH - 1);
      grant_q       <= '0;
      grant_ch_q    <= '0;
      grant_valid_q <= 1'b0;
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_ch_q   <= active_ch_d;
      last_ch_q     <= last_ch_d;
      grant_q       <= grant_d;
      grant_ch_q    <= grant_ch_d;
      grant_valid_q <= grant_valid_d;
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_found) state_d = GRANT;
      GRANT:   if (burst_ack) state_d = burst_done ? IDLE : BURST;
      BURST:   if (burst_done || to_expired) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping
  always_comb begin
    active_ch_d   = active_ch_q;
    last_ch_d     = last_ch_q;
    grant_d       = grant_q;
    grant_ch_d    = grant_ch_q;
    grant_valid_d = grant_valid_q;
    to_cnt_d      = to_cnt_q;
    // A timeout below overrides a simultaneous clear
    timeout_err_d = err_clr ? 1'b0 : timeout_err_q;
    unique case (state_q)
      IDLE: begin
        active_ch_d = clamp_cnt;
        if (arb_found) begin
          for (int i = 0; i < NUM_CH; i++) grant_d[i] = (CH_W'(i) == arb_win);
          grant_ch_d    = arb_win;
          grant_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (burst_ack) begin
          grant_valid_d = 1'b0;
          to_cnt_d      = '0;
          if (burst_done) begin
            grant_d   = '0;
            last_ch_d = grant_ch_q;
          end
        end
      end
      BURST: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (burst_done) begin
          grant_d   = '0;
          last_ch_d = grant_ch_q;
        end else if (to_expired) begin
          // The timed-out channel forfeits its turn
          grant_d       = '0;
          last_ch_d     = grant_ch_q;
          timeout_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign grant       = grant_q;
  assign grant_ch    = grant_ch_q;
  assign grant_valid = grant_valid_q;
  assign active_ch   = active_ch_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != IDLE);

`ifdef CAM_SCHED_STATS_EN
  logic              burst_complete;
  logic [STAT_W-1:0] stat_cnt_q [NUM_CH];
  logic [STAT_W-1:0] stat_cnt_d [NUM_CH];
  logic [STAT_W-1:0] stat_count_q, stat_count_d;

  // Count completed bursts per channel and select the readback value
  always_comb begin
    burst_complete = ((state_q == GRANT) && burst_ack && burst_done) ||
                     ((state_q == BURST) && burst_done);
    stat_count_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      stat_cnt_d[i] = stat_cnt_q[i];
      if (burst_complete && (CH_W'(i) == grant_ch_q)) stat_cnt_d[i] = stat_cnt_q[i] + STAT_W'(1);
      if (CH_W'(i) == stat_sel) stat_count_d = stat_cnt_q[i];
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) stat_cnt_q[i] <= '0;
      stat_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) stat_cnt_q[i] <= stat_cnt_d[i];
      stat_count_q <= stat_count_d;
    end
  end

  assign stat_count = stat_count_q;
`endif

endmodule

// File: tb/tb_cam_channel_scheduler.sv
// Testbench for cam_channel_scheduler: directed vector table, hand-written
// corner sequences and randomized stimulus, all checked every cycle against
// a transaction-level reference model. Stats checks apply when
// CAM_SCHED_STATS_EN is defined.
module tb_cam_channel_scheduler;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int TO     = 16;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        cnt;
  logic [NUM_CH-1:0] req;
  logic              ack, done, err_clr;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_ch;
  logic              grant_valid, busy, timeout_err;
  logic [3:0]        active_ch;
`ifdef CAM_SCHED_STATS_EN
  logic [CH_W-1:0]   stat_sel;
  logic [15:0]       stat_count;
`endif

  always #5 clk = ~clk;

  cam_channel_scheduler #(
    .NUM_CH      (NUM_CH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .no_of_cam_channels (cnt),
    .req                (req),
    .grant              (grant),
    .grant_ch           (grant_ch),
    .grant_valid        (grant_valid),
    .burst_ack          (ack),
    .burst_done         (done),
    .active_ch          (active_ch),
    .busy               (busy),
    .timeout_err        (timeout_err),
    .err_clr            (err_clr)
`ifdef CAM_SCHED_STATS_EN
    ,
    .stat_sel           (stat_sel),
    .stat_count         (stat_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [CH_W-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: channel holding the grant (-1 none); acked: burst started
  int m_owner, m_acked, m_age, m_last, m_cnt, m_gch, m_err;
  int m_stat[NUM_CH];
  int m_stat_out;

  task automatic end_burst(input int completed);
    if (completed != 0) m_stat[m_owner] = (m_stat[m_owner] + 1) % 65536;
    m_last  = m_owner;
    m_owner = -1;
    m_acked = 0;
  endtask

  task automatic model_edge();
    int first, c, win;
    if (reset) begin
      m_owner = -1; m_acked = 0; m_age = 0; m_last = NUM_CH - 1;
      m_cnt = 0; m_gch = 0; m_err = 0; m_stat_out = 0;
      for (int i = 0; i < NUM_CH; i++) m_stat[i] = 0;
      return;
    end
`ifdef CAM_SCHED_STATS_EN
    m_stat_out = m_stat[stat_sel];
`endif
    if (err_clr) m_err = 0;
    if (m_owner < 0) begin
      m_cnt = (int'(cnt) > NUM_CH) ? NUM_CH : int'(cnt);
      win = -1;
      if (m_cnt > 0) begin
        first = (m_last + 1 >= m_cnt) ? 0 : m_last + 1;
        for (int k = 0; k < m_cnt; k++) begin
          c = (first + k) % m_cnt;
          if (req[c]) begin
            win = c;
            break;
          end
        end
      end
      if (win >= 0) begin
        m_owner = win; m_gch = win; m_acked = 0;
      end
    end else if (m_acked == 0) begin
      if (ack) begin
        if (done) end_burst(1);
        else begin
          m_acked = 1; m_age = 0;
        end
      end
    end else begin
      if (done) end_burst(1);
      else if (m_age == TO - 1) begin
        end_burst(0);
        m_err = 1;
      end else m_age++;
    end
  endtask

  task automatic compare_all();
    int exp_grant;
    exp_grant = (m_owner >= 0) ? (1 << m_owner) : 0;
    chk("grant", int'(grant), exp_grant);
    chk("grant_ch", int'(grant_ch), m_gch);
    chk("grant_valid", int'(grant_valid), (m_owner >= 0 && m_acked == 0) ? 1 : 0);
    chk("busy", int'(busy), (m_owner >= 0) ? 1 : 0);
    chk("active_ch", int'(active_ch), m_cnt);
    chk("timeout_err", int'(timeout_err), m_err);
`ifdef CAM_SCHED_STATS_EN
    chk("stat_count", int'(stat_count), m_stat_out);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // One clock: inputs are already set; model follows the edge, compare at negedge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; ack = 1'b0; done = 1'b0; err_clr = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int limit, output bit ok);
    int n;
    n = 0;
    while (!grant_valid && n < limit) begin
      step();
      n++;
    end
    ok = grant_valid;
    if (!ok) chk("grant_wait_bound", 0, 1);
  endtask

  // Serve the presented grant: ack next, done a few cycles later
  task automatic run_burst();
    logic [CH_W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grant_seq", int'(grant_ch), int'(e));
    end
    ack = 1'b1; step(); ack = 1'b0;
    step();
    step();
    done = 1'b1; step(); done = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]        cnt;
    logic [NUM_CH-1:0] req;
    int                n;
    int                exp_active;
    int                seq[8];
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    int n, gv_seen;

    reset = 1'b1; cnt = '0; req = '0; ack = 1'b0; done = 1'b0; err_clr = 1'b0;
`ifdef CAM_SCHED_STATS_EN
    stat_sel = '0;
`endif
    m_owner = -1; m_acked = 0; m_age = 0; m_last = NUM_CH - 1;
    m_cnt = 0; m_gch = 0; m_err = 0; m_stat_out = 0;
    for (int i = 0; i < NUM_CH; i++) m_stat[i] = 0;

    vecs[0] = '{4'd4,  8'hFF, 5, 4, '{0, 1, 2, 3, 0, 0, 0, 0}};
    vecs[1] = '{4'd12, 8'hFF, 8, 8, '{0, 1, 2, 3, 4, 5, 6, 7}};
    vecs[2] = '{4'd4,  8'h0A, 3, 4, '{1, 3, 1, 0, 0, 0, 0, 0}};
    vecs[3] = '{4'd8,  8'h90, 3, 8, '{4, 7, 4, 0, 0, 0, 0, 0}};
    vecs[4] = '{4'd15, 8'h81, 3, 8, '{0, 7, 0, 0, 0, 0, 0, 0}};

    // Reset state
    do_reset();
    chk("reset_grant_valid", int'(grant_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_active_ch", int'(active_ch), 0);

    // Table-driven grant sequences
    foreach (vecs[v]) begin
      do_reset();
      cnt = vecs[v].cnt;
      req = vecs[v].req;
      for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(CH_W'(vecs[v].seq[k]));
      for (int k = 0; k < vecs[v].n; k++) begin
        wait_grant(20, ok);
        if (!ok) break;
        run_burst();
      end
      chk("row_active_ch", int'(active_ch), vecs[v].exp_active);
      chk("row_seq_consumed", exp_q.size(), 0);
      exp_q.delete();
    end

    // Zero channels: nothing is ever granted
    do_reset();
    cnt = 4'd0; req = 8'hFF; gv_seen = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (grant_valid || busy) gv_seen++;
    end
    chk("zero_ch_no_grant", gv_seen, 0);

    // Count shrinks to 2 while channel 5 is bursting
    do_reset();
    cnt = 4'd8; req = 8'hFF;
    for (int k = 0; k < 6; k++) exp_q.push_back(CH_W'(k));
    for (int k = 0; k < 5; k++) begin
      wait_grant(20, ok);
      run_burst();
    end
    wait_grant(20, ok);
    chk("shrink_grant5", int'(grant_ch), int'(exp_q.pop_front()));
    ack = 1'b1; step(); ack = 1'b0;
    cnt = 4'd2;
    step(); step(); step();
    chk("shrink_active_held", int'(active_ch), 8);
    chk("shrink_still_busy", int'(busy), 1);
    done = 1'b1; step(); done = 1'b0;
    wait_grant(20, ok);
    chk("shrink_next_ch0", int'(grant_ch), 0);
    chk("shrink_active_now", int'(active_ch), 2);

    // Timeout: ack without done
    do_reset();
    cnt = 4'd4; req = 8'hFF;
    wait_grant(20, ok);
    chk("to_first_ch", int'(grant_ch), 0);
    ack = 1'b1; step(); ack = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_err_set", int'(timeout_err), 1);
    wait_grant(20, ok);
    chk("to_next_ch", int'(grant_ch), 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("to_err_cleared", int'(timeout_err), 0);
    // done on the final timeout cycle wins
    ack = 1'b1; step(); ack = 1'b0;
    for (int k = 0; k < TO - 1; k++) step();
    chk("to_edge_busy", int'(busy), 1);
    done = 1'b1; step(); done = 1'b0;
    chk("to_edge_idle", int'(busy), 0);
    chk("to_edge_no_err", int'(timeout_err), 0);

`ifdef CAM_SCHED_STATS_EN
    // Stats: three completions on ch1, one timeout on ch2
    do_reset();
    cnt = 4'd4; req = 8'h02;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(CH_W'(1));
      wait_grant(20, ok);
      run_burst();
    end
    req = 8'h04;
    wait_grant(20, ok);
    chk("stat_to_ch", int'(grant_ch), 2);
    ack = 1'b1; step(); ack = 1'b0;
    req = 8'h00;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    stat_sel = 3'd1; step();
    chk("stat_ch1", int'(stat_count), 3);
    stat_sel = 3'd2; step();
    chk("stat_ch2", int'(stat_count), 0);
`endif

    // Randomized traffic against the model
    do_reset();
    cnt = 4'd8;
    for (int k = 0; k < 3000; k++) begin
      reset   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 24) == 0) cnt = 4'($urandom_range(0, 15));
      req     = NUM_CH'($urandom);
      ack     = ($urandom_range(0, 2) == 0);
      done    = ($urandom_range(0, 5) == 0);
      err_clr = ($urandom_range(0, 30) == 0);
`ifdef CAM_SCHED_STATS_EN
      stat_sel = CH_W'($urandom_range(0, NUM_CH - 1));
`endif
      step();
    end
    reset = 1'b0; ack = 1'b0; done = 1'b0; err_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
